// File: rtl/axi_stream_burst_writer.sv
// Single-shot AXI4 INCR write burst controller: pulls words from a ready/valid
// source FIFO, writes them as one burst, appends a zero-strobe beat, then latches done.
module axi_stream_burst_writer (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] m_axi_awaddr,
   output logic [1:0]  m_axi_awburst,
   output logic [7:0]  m_axi_awlen,
   output logic [2:0]  m_axi_awsize,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   output logic        m_axi_bready,
   output logic        m_axi_rready,
   output logic        m_axi_arvalid,
   output logic [15:0] m_axi_araddr,
   output logic [1:0]  m_axi_arburst,
   output logic [7:0]  m_axi_arlen,
   output logic [2:0]  m_axi_arsize,
   input  logic        m_axi_bvalid,
   input  logic        m_axi_rvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [31:0] src_out_data,
   input  logic        src_read_ready,
   output logic        src_read_valid,
   output logic [31:0] src_in_data,
   output logic        src_write_valid,
   input  logic        src_write_ready,
   output logic [7:0]  len_raddr,
   input  logic [7:0]  len_rdata,
   output logic [7:0]  len_waddr,
   output logic [7:0]  len_wdata,
   output logic        len_wen,
   output logic [15:0] addr_raddr,
   input  logic [15:0] addr_rdata,
   output logic [15:0] addr_waddr,
   output logic [15:0] addr_wdata,
   output logic        addr_wen,
   output logic        valid
);

   typedef enum logic [3:0] {
      S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4,
      S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8, S9 = 4'd9
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_len_q, w_len_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [31:0] r_data_q, w_data_nxt;
   logic        r_first, w_first_nxt;
   logic [7:0]  w_cnt_sel;
   logic [7:0]  w_cnt_inc;
   logic        w_unused;

   // Loop-carried counter: first pass starts from zero, later passes from the previous count.
   assign w_cnt_sel = r_first ? 8'd0 : r_cnt;
   assign w_cnt_inc = w_cnt_sel + 8'd1;

   assign m_axi_awaddr    = addr_rdata;
   assign m_axi_awlen     = len_rdata;
   assign m_axi_awburst   = 2'b01;
   assign m_axi_awsize    = 3'b101;
   assign m_axi_bready    = 1'b0;
   assign m_axi_rready    = 1'b0;
   assign m_axi_arvalid   = 1'b0;
   assign m_axi_araddr    = 16'd0;
   assign m_axi_arburst   = 2'd0;
   assign m_axi_arlen     = 8'd0;
   assign m_axi_arsize    = 3'd0;
   assign src_in_data     = 32'd0;
   assign src_write_valid = 1'b0;
   assign len_raddr       = 8'd0;
   assign len_waddr       = 8'd0;
   assign len_wdata       = 8'd0;
   assign len_wen         = 1'b0;
   assign addr_raddr      = 16'd0;
   assign addr_waddr      = 16'd0;
   assign addr_wdata      = 16'd0;
   assign addr_wen        = 1'b0;
   assign w_unused        = ^{m_axi_bvalid, m_axi_rvalid, m_axi_arready, m_axi_rdata, src_write_ready};

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S0;
         r_len_q  <= 8'd0;
         r_cnt    <= 8'd0;
         r_data_q <= 32'd0;
         r_first  <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_len_q  <= w_len_nxt;
         r_cnt    <= w_cnt_nxt;
         r_data_q <= w_data_nxt;
         r_first  <= w_first_nxt;
      end
   end

   // Next-state and output decode.
   always_comb begin
      w_state_nxt    = r_state;
      w_len_nxt      = r_len_q;
      w_cnt_nxt      = r_cnt;
      w_data_nxt     = r_data_q;
      w_first_nxt    = r_first;
      m_axi_awvalid  = 1'b0;
      m_axi_wvalid   = 1'b0;
      m_axi_wdata    = 32'd0;
      m_axi_wstrb    = 4'h0;
      src_read_valid = 1'b0;
      valid          = 1'b0;
      case (r_state)
         S0: begin
            m_axi_awvalid = m_axi_awready;
            m_axi_wvalid  = m_axi_awready;
            w_first_nxt   = 1'b1;
            if (m_axi_awready) begin
               w_len_nxt   = len_rdata;
               w_state_nxt = S1;
            end else begin
               w_state_nxt = S0;
            end
         end
         S1: begin
            if (src_read_ready) begin
               w_cnt_nxt   = w_cnt_inc;
               w_state_nxt = S2;
            end else begin
               w_state_nxt = S1;
            end
         end
         S2: begin
            src_read_valid = 1'b1;
            w_state_nxt    = S3;
         end
         S3: begin
            w_data_nxt  = src_out_data;
            w_state_nxt = S4;
         end
         S4: begin
            if (m_axi_wready) begin
               w_state_nxt = S5;
            end else begin
               w_state_nxt = S4;
            end
         end
         S5: begin
            m_axi_wvalid = 1'b1;
            m_axi_wdata  = r_data_q;
            m_axi_wstrb  = 4'hF;
            w_state_nxt  = S6;
         end
         S6: begin
            w_first_nxt = 1'b0;
            // Signed compare: lengths of 0 or >= 128 end after a single beat.
            if ($signed(r_cnt) < $signed(r_len_q)) begin
               w_state_nxt = S1;
            end else begin
               w_state_nxt = S7;
            end
         end
         S7: begin
            if (m_axi_wready) begin
               w_state_nxt = S8;
            end else begin
               w_state_nxt = S7;
            end
         end
         S8: begin
            m_axi_wvalid = 1'b1;
            w_state_nxt  = S9;
         end
         S9: begin
            valid       = 1'b1;
            w_state_nxt = S9;
         end
         default: begin
            w_state_nxt = S0;
         end
      endcase
   end

endmodule

// File: tb/tb_axi_stream_burst_writer.sv
// Directed bench for axi_stream_burst_writer: a cycle-by-cycle vector table for a
// len=3 burst plus hand-written sequences for stalls, length corner cases and reset.
module tb_axi_stream_burst_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] m_axi_awaddr;
   logic [1:0]  m_axi_awburst;
   logic [7:0]  m_axi_awlen;
   logic [2:0]  m_axi_awsize;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic        m_axi_bready, m_axi_rready, m_axi_arvalid;
   logic [15:0] m_axi_araddr;
   logic [1:0]  m_axi_arburst;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic        m_axi_bvalid, m_axi_rvalid, m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [31:0] src_out_data;
   logic        src_read_ready;
   logic        src_read_valid;
   logic [31:0] src_in_data;
   logic        src_write_valid;
   logic        src_write_ready;
   logic [7:0]  len_raddr, len_rdata, len_waddr, len_wdata;
   logic        len_wen;
   logic [15:0] addr_raddr, addr_rdata, addr_waddr, addr_wdata;
   logic        addr_wen;
   logic        valid;

   int n_vec  = 0;
   int n_fail = 0;

   axi_stream_burst_writer dut (
      .clk(clk), .rst(rst),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awburst(m_axi_awburst), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready), .m_axi_bready(m_axi_bready), .m_axi_rready(m_axi_rready),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arburst(m_axi_arburst),
      .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
      .src_out_data(src_out_data), .src_read_ready(src_read_ready), .src_read_valid(src_read_valid),
      .src_in_data(src_in_data), .src_write_valid(src_write_valid), .src_write_ready(src_write_ready),
      .len_raddr(len_raddr), .len_rdata(len_rdata), .len_waddr(len_waddr), .len_wdata(len_wdata),
      .len_wen(len_wen), .addr_raddr(addr_raddr), .addr_rdata(addr_rdata), .addr_waddr(addr_waddr),
      .addr_wdata(addr_wdata), .addr_wen(addr_wen), .valid(valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        aw, rr, wr;
      logic [31:0] din;
      logic        e_aw, e_w;
      logic [31:0] e_wd;
      logic [3:0]  e_ws;
      logic        e_rv, e_v;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(input logic aw, input logic rr, input logic wr, input logic [31:0] din,
                               input logic e_aw, input logic e_w, input logic [31:0] e_wd,
                               input logic [3:0] e_ws, input logic e_rv, input logic e_v);
      vec_t v;
      v.aw = aw; v.rr = rr; v.wr = wr; v.din = din;
      v.e_aw = e_aw; v.e_w = e_w; v.e_wd = e_wd; v.e_ws = e_ws; v.e_rv = e_rv; v.e_v = e_v;
      return v;
   endfunction

   function automatic logic [31:0] word_of(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] out_pack();
      return {m_axi_awaddr, m_axi_awlen, m_axi_awvalid, m_axi_wvalid, src_read_valid, valid,
              m_axi_wstrb, m_axi_wdata};
   endfunction

   function automatic logic held_zero_any();
      return |{m_axi_bready, m_axi_rready, m_axi_arvalid, m_axi_araddr, m_axi_arburst, m_axi_arlen,
               m_axi_arsize, src_in_data, src_write_valid, len_raddr, len_waddr, len_wdata, len_wen,
               addr_raddr, addr_waddr, addr_wdata, addr_wen};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; m_axi_awready = 1'b0; m_axi_wready = 1'b0; src_read_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_outputs", {60'd0, m_axi_awvalid, m_axi_wvalid, src_read_valid, valid}, 64'd0);
      chk("reset_fixed", {54'd0, m_axi_awburst, m_axi_awsize, held_zero_any()}, {54'd0, 2'b01, 3'b101, 1'b0});
   endtask

   // One burst driven reactively; expectations come from the length rule only.
   task automatic run_burst(input string tag, input logic [7:0] len, input logic [15:0] addr,
                            input int aw_delay, input int rd_stall, input int wr_stall,
                            input int abort_pulse, input logic skip_reset);
      int exp_beats, pulses, ndata, nzero, bad, first_pulse, cyc;
      logic done;
      exp_beats = (len >= 8'd1 && len <= 8'd127) ? int'(len) : 1;
      pulses = 0; ndata = 0; nzero = 0; bad = 0; first_pulse = -1; done = 1'b0;
      if (!skip_reset) do_reset();
      len_rdata = len; addr_rdata = addr;
      for (int i = 0; i < aw_delay; i++) begin
         @(negedge clk);
         m_axi_awready = 1'b0; src_read_ready = 1'b1; m_axi_wready = 1'b1;
         #1;
         chk({tag, "_aw_wait"}, {61'd0, m_axi_awvalid, m_axi_wvalid, src_read_valid}, 64'd0);
      end
      @(negedge clk);
      m_axi_awready = 1'b1;
      #1;
      chk({tag, "_aw_hs"}, {38'd0, m_axi_awaddr, m_axi_awlen, m_axi_awvalid, m_axi_wvalid},
          {38'd0, addr, len, 1'b1, 1'b1});
      for (cyc = 1; cyc < 1000; cyc++) begin
         @(negedge clk);
         m_axi_awready  = 1'b0;
         src_read_ready = (cyc <= rd_stall) ? 1'b0 : 1'b1;
         m_axi_wready   = (first_pulse > 0 && cyc >= first_pulse + 2 && cyc < first_pulse + 2 + wr_stall)
                          ? 1'b0 : 1'b1;
         src_out_data   = (pulses > 0) ? word_of(pulses - 1) : 32'hDEAD_BEEF;
         #1;
         if (src_read_valid) begin
            if (!src_read_ready && cyc <= rd_stall) bad++;
            pulses++;
            if (first_pulse < 0) first_pulse = cyc;
         end
         if (m_axi_wvalid) begin
            if (!m_axi_wready) bad++;
            if (m_axi_wstrb == 4'hF) begin
               if (m_axi_wdata !== word_of(ndata)) bad++;
               ndata++;
            end else if (m_axi_wstrb == 4'h0 && m_axi_wdata == 32'd0) begin
               nzero++;
            end else begin
               bad++;
            end
         end
         if (abort_pulse > 0 && pulses == abort_pulse) break;
         if (valid) begin
            done = 1'b1;
            break;
         end
      end
      if (abort_pulse > 0) begin
         chk({tag, "_abort_reached"}, 64'(pulses), 64'(abort_pulse));
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0; m_axi_awready = 1'b0;
         #1;
         chk({tag, "_rst_s0"}, {60'd0, m_axi_awvalid, m_axi_wvalid, src_read_valid, valid}, 64'd0);
         m_axi_awready = 1'b1;
         #1;
         chk({tag, "_rst_s0_aw"}, {62'd0, m_axi_awvalid, m_axi_wvalid}, 64'd3);
         m_axi_awready = 1'b0;
      end else begin
         chk({tag, "_done"}, {63'd0, done}, 64'd1);
         chk({tag, "_data_beats"}, 64'(ndata), 64'(exp_beats));
         chk({tag, "_zero_beats"}, 64'(nzero), 64'd1);
         chk({tag, "_pops"}, 64'(pulses), 64'(exp_beats));
         chk({tag, "_violations"}, 64'(bad), 64'd0);
      end
   endtask

   initial begin
      rst = 1'b1;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; src_read_ready = 1'b0;
      src_out_data = 32'd0; len_rdata = 8'd3; addr_rdata = 16'h1000;
      m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_arready = 1'b0; m_axi_rdata = 32'd0;
      src_write_ready = 1'b0;

      // len=3 burst, cycle by cycle: S0, then S1..S6 per beat, then S7, S8, S9, S9.
      vecs[0] = mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0, 4'h0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         logic [31:0] w;
         w = 32'hA + 32'(k);
         vecs[1 + 6*k] = mk(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0);
         vecs[2 + 6*k] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'h0, 1'b1, 1'b0);
         vecs[3 + 6*k] = mk(1'b0, 1'b0, 1'b0, w,     1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0);
         vecs[4 + 6*k] = mk(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0);
         vecs[5 + 6*k] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, w,     4'hF, 1'b0, 1'b0);
         vecs[6 + 6*k] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0);
      end
      vecs[19] = mk(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b0);
      vecs[20] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 4'h0, 1'b0, 1'b0);
      vecs[21] = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b1);
      vecs[22] = mk(1'b1, 1'b1, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 32'd0, 4'h0, 1'b0, 1'b1);

      do_reset();
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         m_axi_awready = vecs[i].aw; src_read_ready = vecs[i].rr;
         m_axi_wready = vecs[i].wr; src_out_data = vecs[i].din;
         #1;
         chk($sformatf("table_vec%0d", i), out_pack(),
             {16'h1000, 8'd3, vecs[i].e_aw, vecs[i].e_w, vecs[i].e_rv, vecs[i].e_v,
              vecs[i].e_ws, vecs[i].e_wd});
      end

      run_burst("len1_awdelay5", 8'd1,   16'h2000, 5, 0, 0, 0, 1'b0);
      run_burst("len0",          8'd0,   16'h2100, 0, 0, 0, 0, 1'b0);
      run_burst("len80",         8'h80,  16'h2200, 0, 0, 0, 0, 1'b0);
      run_burst("len3_stall",    8'd3,   16'h2300, 0, 3, 4, 0, 1'b0);
      run_burst("len4_abort",    8'd4,   16'h2400, 0, 0, 0, 2, 1'b0);
      run_burst("len4_rerun",    8'd4,   16'h2400, 0, 0, 0, 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
